// File: rtl/seq_pkg.sv
// Shared types and instruction-format constants for the instruction sequencer
// and for anything that decodes the 16-bit processor instruction word.
package seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      WAIT,
      HALT
   } state_t;

   localparam logic [1:0] OP_MV   = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_MULT = 2'b11;

   // Bit positions inside an instruction word: II opcode, M immediate flag,
   // X destination register, D immediate data, Y source register.
   localparam int II_HI = 15;
   localparam int II_LO = 14;
   localparam int M_BIT = 13;
   localparam int X_BIT = 12;
   localparam int D_HI  = 11;
   localparam int D_LO  = 0;
   localparam int Y_BIT = 0;

   function automatic logic [1:0] get_op(input logic [15:0] instr);
      return instr[II_HI:II_LO];
   endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program memory: DEPTH x IW, synchronous write and registered read, no reset.
// A write and a read to the same address in one cycle return the new data.
module seq_prog_mem #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH),
   parameter int IW    = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [IW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [IW-1:0] rdata
);

   logic [IW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      // Bypass keeps "write then start in the same cycle" fetching the fresh word.
      if (re) begin
         rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Run/done initiator: walks a loaded program, one run pulse per word, waiting
// for done before advancing. Optional retired counter under SEQ_INSTR_COUNT_EN.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH),
   parameter int IW    = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW:0]   prog_len,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [IW-1:0] prog_wdata,
   input  logic          done_in,
   output logic          run_out,
   output logic [IW-1:0] instr_out,
   output logic          busy,
   output logic          halted,
   output logic [AW-1:0] pc
`ifdef SEQ_INSTR_COUNT_EN
   ,
   output logic [15:0]   retired_cnt
`endif
);

   state_t        state_reg, state_next;
   logic [AW-1:0] pc_reg, pc_next;
   logic [AW:0]   len_reg, len_next;
   logic [IW-1:0] instr_reg;
   logic [IW-1:0] rd_data;
   logic [AW-1:0] rd_addr;
   logic          rd_en;
   logic          idle_like;
   logic          start_ok;
   logic          done_ok;
   logic          last_instr;
   logic          wr_en;

   assign idle_like  = (state_reg == IDLE) || (state_reg == HALT);
   assign start_ok   = start && idle_like;
   assign done_ok    = done_in && (state_reg == WAIT);
   assign last_instr = ({1'b0, pc_reg} == (len_reg - (AW+1)'(1)));
   assign wr_en      = prog_we && idle_like;

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      len_next   = len_reg;
      case (state_reg)
         IDLE, HALT: begin
            if (start) begin
               if (prog_len != '0) begin
                  len_next   = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
                  pc_next    = '0;
                  state_next = FETCH;
               end else begin
                  state_next = HALT;
               end
            end
         end
         FETCH: state_next = ISSUE;
         ISSUE: state_next = WAIT;
         WAIT: begin
            if (done_in) begin
               if (last_instr) begin
                  state_next = HALT;
               end else begin
                  pc_next    = pc_reg + 1'b1;
                  state_next = FETCH;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Read is launched on the edge that enters FETCH so the word is ready to
   // be registered onto instr_out for the whole ISSUE cycle.
   assign rd_en   = (state_next == FETCH);
   assign rd_addr = pc_next;

   seq_prog_mem #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .IW    (IW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (prog_addr),
      .wdata (prog_wdata),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         pc_reg    <= '0;
         len_reg   <= '0;
         instr_reg <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         len_reg   <= len_next;
         if (state_reg == FETCH) begin
            instr_reg <= rd_data;
         end
      end
   end

   assign run_out   = (state_reg == ISSUE);
   assign busy      = (state_reg == FETCH) || (state_reg == ISSUE) || (state_reg == WAIT);
   assign halted    = (state_reg == HALT);
   assign instr_out = instr_reg;
   assign pc        = pc_reg;

`ifdef SEQ_INSTR_COUNT_EN
   logic [15:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (reset || start_ok) begin
         cnt_reg <= '0;
      end else if (done_ok) begin
         cnt_reg <= cnt_reg + 16'd1;
      end
   end

   assign retired_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: run/done timing, length limits, reset
// abort, write/start gating, plus a tiny r0-only processor model.
module tb_instr_sequencer;
   import seq_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int IW    = 16;

   logic          clk;
   logic          reset;
   logic          start;
   logic [AW:0]   prog_len;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [IW-1:0] prog_wdata;
   logic          done_in;
   logic          run_out;
   logic [IW-1:0] instr_out;
   logic          busy;
   logic          halted;
   logic [AW-1:0] pc;
`ifdef SEQ_INSTR_COUNT_EN
   logic [15:0]   retired_cnt;
`endif

   int total = 0;
   int bad   = 0;
   int run_cnt = 0;
   logic [15:0] r0_model = 16'd0;

   instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .prog_len   (prog_len),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_wdata (prog_wdata),
      .done_in    (done_in),
      .run_out    (run_out),
      .instr_out  (instr_out),
      .busy       (busy),
      .halted     (halted),
      .pc         (pc)
`ifdef SEQ_INSTR_COUNT_EN
      ,
      .retired_cnt(retired_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Processor stand-in: executes immediate-form ops on r0 when run is seen.
   always @(negedge clk) begin
      if (run_out) begin
         logic [15:0] opnd;
         run_cnt++;
         opnd = instr_out[M_BIT] ? {4'd0, instr_out[D_HI:D_LO]} : r0_model;
         case (get_op(instr_out))
            OP_MV:   r0_model = opnd;
            OP_ADD:  r0_model = r0_model + opnd;
            OP_SUB:  r0_model = r0_model - opnd;
            default: r0_model = r0_model * opnd;
         endcase
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
      prog_we = 1'b1; prog_addr = a; prog_wdata = d;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic start_prog(input logic [AW:0] len);
      prog_len = len; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Entered on the ISSUE cycle; answers done after lat cycles, returns one cycle later.
   task automatic run_one(input logic [15:0] exp, input int lat, input int exp_pc, input string tag);
      total++; if (run_out !== 1'b1) begin bad++; $display("FAIL %s run_out act=%0b exp=1", tag, run_out); end
      total++; if (instr_out !== exp) begin bad++; $display("FAIL %s instr act=%h exp=%h", tag, instr_out, exp); end
      total++; if (pc !== AW'(exp_pc)) begin bad++; $display("FAIL %s pc act=%0d exp=%0d", tag, pc, exp_pc); end
      $display("issue %s pc=%0d instr=%h lat=%0d", tag, pc, instr_out, lat);
      for (int i = 1; i <= lat; i++) begin
         tick();
         if (i == lat) done_in = 1'b1;
         total++; if (run_out !== 1'b0) begin bad++; $display("FAIL %s wait_run act=%0b exp=0", tag, run_out); end
         total++; if (instr_out !== exp) begin bad++; $display("FAIL %s hold act=%h exp=%h", tag, instr_out, exp); end
      end
      tick();
      done_in = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      total++; if (run_out !== 1'b0) begin bad++; $display("FAIL reset run_out act=%0b exp=0", run_out); end
      total++; if (instr_out !== 16'h0) begin bad++; $display("FAIL reset instr act=%h exp=0000", instr_out); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy act=%0b exp=0", busy); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset halted act=%0b exp=0", halted); end
      total++; if (pc !== 4'd0) begin bad++; $display("FAIL reset pc act=%0d exp=0", pc); end
      reset = 1'b0;
      tick();
      $display("reset done");
   endtask

   task automatic test_mv_add();
      load(4'd0, 16'h2005);
      load(4'd1, 16'h6003);
      run_cnt = 0; r0_model = 16'd0;
      start_prog(5'd2);
      total++; if (busy !== 1'b1 || run_out !== 1'b0) begin bad++; $display("FAIL mv_add fetch busy/run act=%0b/%0b exp=1/0", busy, run_out); end
      tick();
      run_one(16'h2005, 1, 0, "mv");
      tick();
      run_one(16'h6003, 1, 1, "add");
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL mv_add halted act=%0b exp=1", halted); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mv_add busy act=%0b exp=0", busy); end
      total++; if (run_cnt !== 2) begin bad++; $display("FAIL mv_add runs act=%0d exp=2", run_cnt); end
      total++; if (r0_model !== 16'd8) begin bad++; $display("FAIL mv_add r0 act=%0d exp=8", r0_model); end
      total++; if (instr_out !== 16'h6003) begin bad++; $display("FAIL mv_add last_instr act=%h exp=6003", instr_out); end
`ifdef SEQ_INSTR_COUNT_EN
      total++; if (retired_cnt !== 16'd2) begin bad++; $display("FAIL mv_add retired act=%0d exp=2", retired_cnt); end
`endif
   endtask

   task automatic test_latency();
      r0_model = 16'd0;
      start_prog(5'd2);
      total++; if (run_out !== 1'b0) begin bad++; $display("FAIL latency t+1 run act=%0b exp=0", run_out); end
      tick();
      run_one(16'h2005, 1, 0, "lat1");
      total++; if (run_out !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL latency d+1 run/busy act=%0b/%0b exp=0/1", run_out, busy); end
      tick();
      run_one(16'h6003, 3, 1, "lat3");
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL latency halted act=%0b exp=1", halted); end
      total++; if (r0_model !== 16'd8) begin bad++; $display("FAIL latency r0 act=%0d exp=8", r0_model); end
   endtask

   task automatic test_zero_len();
      reset = 1'b1; tick(); reset = 1'b0;
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL zero_len pre_halted act=%0b exp=0", halted); end
      run_cnt = 0;
      start_prog(5'd0);
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL zero_len halted act=%0b exp=1", halted); end
      for (int i = 0; i < 3; i++) begin
         total++; if (run_out !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL zero_len run/busy act=%0b/%0b exp=0/0", run_out, busy); end
         tick();
      end
      total++; if (run_cnt !== 0) begin bad++; $display("FAIL zero_len runs act=%0d exp=0", run_cnt); end
      $display("zero_len done");
   endtask

   task automatic test_full_depth();
      for (int i = 0; i < DEPTH; i++) load(AW'(i), 16'h1000 + 16'(i));
      run_cnt = 0;
      start_prog(5'd19);
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         run_one(16'h1000 + 16'(i), 1, i, "full");
      end
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL full halted act=%0b exp=1", halted); end
      total++; if (pc !== 4'd15) begin bad++; $display("FAIL full pc act=%0d exp=15", pc); end
      total++; if (run_cnt !== DEPTH) begin bad++; $display("FAIL full runs act=%0d exp=%0d", run_cnt, DEPTH); end
`ifdef SEQ_INSTR_COUNT_EN
      total++; if (retired_cnt !== 16'd16) begin bad++; $display("FAIL full retired act=%0d exp=16", retired_cnt); end
`endif
   endtask

   task automatic test_reset_mid();
      start_prog(5'd3);
      tick();
      run_one(16'h1000, 1, 0, "mid0");
      tick();
      total++; if (run_out !== 1'b1 || instr_out !== 16'h1001) begin bad++; $display("FAIL mid issue2 run/instr act=%0b/%h exp=1/1001", run_out, instr_out); end
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      run_cnt = 0;
      total++; if (busy !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL mid busy/halted act=%0b/%0b exp=0/0", busy, halted); end
      total++; if (run_out !== 1'b0) begin bad++; $display("FAIL mid run act=%0b exp=0", run_out); end
      total++; if (pc !== 4'd0) begin bad++; $display("FAIL mid pc act=%0d exp=0", pc); end
      total++; if (instr_out !== 16'h0) begin bad++; $display("FAIL mid instr act=%h exp=0000", instr_out); end
      tick(); tick(); tick();
      total++; if (run_cnt !== 0) begin bad++; $display("FAIL mid stray_runs act=%0d exp=0", run_cnt); end
      start_prog(5'd1);
      tick();
      run_one(16'h1000, 1, 0, "restart");
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL mid restart_halted act=%0b exp=1", halted); end
   endtask

   task automatic test_busy_guard();
      run_cnt = 0;
      prog_len = 5'd2; start = 1'b1;
      tick();
      // In FETCH: write, spurious done and a second start must all be ignored.
      prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 16'hFFFF; done_in = 1'b1;
      tick();
      prog_we = 1'b0; done_in = 1'b0; start = 1'b0;
      run_one(16'h1000, 1, 0, "guard0");
      tick();
      run_one(16'h1001, 2, 1, "guard1");
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL guard halted act=%0b exp=1", halted); end
      total++; if (run_cnt !== 2) begin bad++; $display("FAIL guard runs act=%0d exp=2", run_cnt); end
`ifdef SEQ_INSTR_COUNT_EN
      total++; if (retired_cnt !== 16'd2) begin bad++; $display("FAIL guard retired act=%0d exp=2", retired_cnt); end
`endif
      start_prog(5'd1);
      tick();
      run_one(16'h1000, 1, 0, "guard_mem");
   endtask

   task automatic test_write_start();
      prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 16'h2222;
      prog_len = 5'd1; start = 1'b1;
      tick();
      prog_we = 1'b0; start = 1'b0;
      tick();
      run_one(16'h2222, 1, 0, "wr_start");
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL wr_start halted act=%0b exp=1", halted); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; prog_len = '0; prog_we = 1'b0;
      prog_addr = '0; prog_wdata = '0; done_in = 1'b0;
      test_reset();
      test_mv_add();
      test_latency();
      test_zero_len();
      test_full_depth();
      test_reset_mid();
      test_busy_guard();
      test_write_start();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
